// File: rtl/arb_credit_bank_if.sv
// Grant handshake bundle between arb_credit_bank (master) and its downstream
// consumer (slave): per-channel requests plus the registered grant offer.
interface arb_credit_bank_if #(
    parameter int NCHAN = 4,
    parameter int IDW   = $clog2(NCHAN)
);
    logic [NCHAN-1:0] req;
    logic             gnt_ready;
    logic             gnt_valid;
    logic [IDW-1:0]   gnt_id;

    modport master (input req, input gnt_ready, output gnt_valid, output gnt_id);
    modport slave  (output req, output gnt_ready, input gnt_valid, input gnt_id);
endinterface

// File: rtl/arb_credit_bank.sv
// NCHAN saturating credit counters with a registered round-robin grant stage.
// Define ARB_CREDIT_ERR_EN to add sticky overflow/underflow flags (err_ovf/err_udf/err_clr).
module arb_credit_bank #(
    parameter int NCHAN      = 4,
    parameter int NBITS      = 4,
    parameter int MAX_CREDIT = 2**NBITS-1,
    parameter int IDW        = $clog2(NCHAN)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NCHAN-1:0]       clear,
    input  logic [NCHAN-1:0]       inc,
    input  logic [NCHAN-1:0]       dec,
    arb_credit_bank_if.master      gnt,
    output logic [NCHAN*NBITS-1:0] count,
    output logic [NCHAN-1:0]       empty,
    output logic [NCHAN-1:0]       full
`ifdef ARB_CREDIT_ERR_EN
    ,
    input  logic                   err_clr,
    output logic [NCHAN-1:0]       err_ovf,
    output logic [NCHAN-1:0]       err_udf
`endif
);

    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [NBITS-1:0] MAXC = NBITS'(MAX_CREDIT);

    state_t           state, state_nxt;
    logic [NBITS-1:0] cnt [NCHAN];
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [IDW-1:0]   gid, gid_nxt;
    logic [IDW-1:0]   cand, pick;
    logic             found;
    logic             accept, withdraw;
    logic [NCHAN-1:0] elig, reserved, consume;

    assign gnt.gnt_valid = (state == OFFER);
    assign gnt.gnt_id    = gid;

    // A clear on the offered channel withdraws the offer and masks gnt_ready.
    assign withdraw = (state == OFFER) && clear[gid];
    assign accept   = (state == OFFER) && gnt.gnt_ready && !clear[gid];

    // NOTE: every signal gets a default at the top of an always_comb so no path can infer a latch.
    always_comb begin
        reserved = '0;
        consume  = '0;
        elig     = '0;
        for (int i = 0; i < NCHAN; i++) begin
            reserved[i] = (state == OFFER) && (gid == IDW'(i));
            consume[i]  = (dec[i] && !reserved[i]) || (accept && reserved[i]);
            elig[i]     = gnt.req[i] && (cnt[i] != '0) && !clear[i] && !dec[i];
        end
    end

    // Round-robin search starting one past the last accepted channel.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = ptr;
        for (int k = 1; k <= NCHAN; k++) begin
            cand = IDW'((int'(ptr) + k) % NCHAN);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gid   <= '0;
            ptr   <= IDW'(NCHAN-1);
        end else begin
            state <= state_nxt;
            gid   <= gid_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = OFFER;
            OFFER:   if (accept || withdraw) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gid_nxt = gid;
        ptr_nxt = ptr;
        if (state == IDLE && found) gid_nxt = pick;
        if (accept)                 ptr_nxt = gid;
    end

    // NOTE: the counter array is a handful of flops, so it takes the async reset like any other state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NCHAN; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (clear[i])
                    cnt[i] <= '0;
                else if (inc[i] && !consume[i] && cnt[i] != MAXC)
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!inc[i] && consume[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always_comb begin
        count = '0;
        empty = '0;
        full  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            count[i*NBITS +: NBITS] = cnt[i];
            empty[i] = (cnt[i] == '0);
            full[i]  = (cnt[i] == MAXC);
        end
    end

`ifdef ARB_CREDIT_ERR_EN
    logic [NCHAN-1:0] ovf_set, udf_set;

    always_comb begin
        ovf_set = '0;
        udf_set = '0;
        for (int i = 0; i < NCHAN; i++) begin
            ovf_set[i] = !clear[i] && inc[i] && !consume[i] && (cnt[i] == MAXC);
            udf_set[i] = !clear[i] && dec[i] && (reserved[i] || (!inc[i] && cnt[i] == '0));
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_ovf <= '0;
            err_udf <= '0;
        end else if (err_clr) begin
            err_ovf <= '0;
            err_udf <= '0;
        end else begin
            err_ovf <= err_ovf | ovf_set;
            err_udf <= err_udf | udf_set;
        end
    end
`endif

endmodule

// File: tb/tb_arb_credit_bank.sv
// Directed and randomized bench for arb_credit_bank against a cycle-level
// behavioural model built from the credit/grant rules with plain integer arithmetic.
module tb_arb_credit_bank;

    localparam int NCHAN = 4;
    localparam int NBITS = 4;
    localparam int MAXC  = 15;
    localparam int IDW   = 2;

    logic                   CLK = 1'b0;
    logic                   nRST = 1'b0;
    logic [NCHAN-1:0]       clear = '0, inc = '0, dec = '0;
    logic [NCHAN*NBITS-1:0] count;
    logic [NCHAN-1:0]       empty, full;
`ifdef ARB_CREDIT_ERR_EN
    logic                   err_clr = 1'b0;
    logic [NCHAN-1:0]       err_ovf, err_udf;
`endif

    arb_credit_bank_if #(.NCHAN(NCHAN), .IDW(IDW)) bus ();

    arb_credit_bank #(.NCHAN(NCHAN), .NBITS(NBITS), .MAX_CREDIT(MAXC), .IDW(IDW)) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .clear  (clear),
        .inc    (inc),
        .dec    (dec),
        .gnt    (bus),
        .count  (count),
        .empty  (empty),
        .full   (full)
`ifdef ARB_CREDIT_ERR_EN
        ,
        .err_clr(err_clr),
        .err_ovf(err_ovf),
        .err_udf(err_udf)
`endif
    );

    always #5 CLK = ~CLK;

    int n_pass = 0, n_fail = 0, n_total = 0;

    // Reference model state
    int m_cnt [NCHAN];
    bit m_pend;
    int m_oid;
    int m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        logic [NCHAN*NBITS-1:0] v;
        v = count;
        return 32'(v[ch*NBITS +: NBITS]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCHAN; i++) m_cnt[i] = 0;
        m_pend = 0;
        m_oid  = 0;
        m_ptr  = NCHAN-1;
    endtask

    task automatic model_next(input logic [3:0] cv, iv, dv, rv, input logic rdy);
        int  nc [NCHAN];
        bit  acc, wd;
        int  used, j;
        acc = m_pend && rdy && !cv[m_oid];
        wd  = m_pend && cv[m_oid];
        for (int i = 0; i < NCHAN; i++) begin
            if (cv[i]) nc[i] = 0;
            else begin
                used  = ((dv[i] && !(m_pend && i == m_oid)) || (acc && i == m_oid)) ? 1 : 0;
                nc[i] = m_cnt[i] + (iv[i] ? 1 : 0) - used;
                if (nc[i] > MAXC) nc[i] = MAXC;
                if (nc[i] < 0)    nc[i] = 0;
            end
        end
        if (m_pend) begin
            if (acc) begin
                m_ptr  = m_oid;
                m_pend = 0;
            end else if (wd) m_pend = 0;
        end else begin
            for (int k = 1; k <= NCHAN; k++) begin
                j = (m_ptr + k) % NCHAN;
                if (!m_pend && rv[j] && m_cnt[j] > 0 && !cv[j] && !dv[j]) begin
                    m_pend = 1;
                    m_oid  = j;
                end
            end
        end
        for (int i = 0; i < NCHAN; i++) m_cnt[i] = nc[i];
    endtask

    task automatic check_model(input string where);
        logic [3:0] e_empty, e_full;
        for (int i = 0; i < NCHAN; i++) begin
            check($sformatf("%s cnt%0d", where, i), cnt_of(i), 32'(m_cnt[i]));
            e_empty[i] = (m_cnt[i] == 0);
            e_full[i]  = (m_cnt[i] == MAXC);
        end
        check({where, " empty"}, 32'(empty), 32'(e_empty));
        check({where, " full"}, 32'(full), 32'(e_full));
        check({where, " gnt_valid"}, 32'(bus.gnt_valid), 32'(m_pend));
        if (m_pend) check({where, " gnt_id"}, 32'(bus.gnt_id), 32'(m_oid));
    endtask

    task automatic step(input logic [3:0] cv, iv, dv, rv, input logic rdy, input string where);
        clear = cv; inc = iv; dec = dv; bus.req = rv; bus.gnt_ready = rdy;
        model_next(cv, iv, dv, rv, rdy);
        @(posedge CLK);
        @(negedge CLK);
        check_model(where);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop without waiting for a clock edge.
    task automatic do_reset(input string where);
        #2;
        nRST = 1'b0;
        clear = '0; inc = '0; dec = '0; bus.req = '0; bus.gnt_ready = 1'b0;
        #1;
        model_reset();
        check({where, " rst count"}, 32'(count), 32'h0);
        check({where, " rst gnt_valid"}, 32'(bus.gnt_valid), 32'h0);
        check({where, " rst gnt_id"}, 32'(bus.gnt_id), 32'h0);
        check({where, " rst empty"}, 32'(empty), 32'hF);
        check({where, " rst full"}, 32'(full), 32'h0);
`ifdef ARB_CREDIT_ERR_EN
        check({where, " rst err_ovf"}, 32'(err_ovf), 32'h0);
        check({where, " rst err_udf"}, 32'(err_udf), 32'h0);
`endif
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids [$];
        int exp_ids [8];
        logic [3:0] rc, ri, rd, rr;
        logic       rrdy;

        bus.req = '0;
        bus.gnt_ready = 1'b0;
        @(negedge CLK);
        do_reset("init");

        // Credit return on ch2, no requests
        for (int n = 0; n < 3; n++) step(4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, "inc2");
        check("inc2 ch2=3", cnt_of(2), 32'd3);
        check("inc2 empty", 32'(empty), 32'b1011);
        check("inc2 no grant", 32'(bus.gnt_valid), 32'h0);

        // Saturation on ch0, then underflow attempt on ch1
        do_reset("sat");
        for (int n = 0; n < 20; n++) step(4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, "sat0");
        check("sat ch0=15", cnt_of(0), 32'd15);
        check("sat full0", 32'(full[0]), 32'h1);
`ifdef ARB_CREDIT_ERR_EN
        check("sat err_ovf0", 32'(err_ovf[0]), 32'h1);
`endif
        step(4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, "udf1");
        check("udf ch1=0", cnt_of(1), 32'd0);
`ifdef ARB_CREDIT_ERR_EN
        check("udf err_udf1", 32'(err_udf[1]), 32'h1);
        err_clr = 1'b1;
        @(posedge CLK); @(negedge CLK);
        err_clr = 1'b0;
        check("udf err_clr", 32'(err_udf[1]), 32'h0);
`endif

        // Round-robin over all channels with two credits each
        do_reset("rr");
        for (int n = 0; n < 2; n++) step(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, "rr fill");
        exp_ids = '{0, 1, 2, 3, 0, 1, 2, 3};
        for (int n = 0; n < 20; n++) begin
            step(4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1, "rr");
            if (bus.gnt_valid === 1'b1) ids.push_back(int'(bus.gnt_id));
        end
        check("rr grant count", 32'(ids.size()), 32'd8);
        for (int n = 0; n < 8 && n < ids.size(); n++)
            check($sformatf("rr seq%0d", n), 32'(ids[n]), 32'(exp_ids[n]));
        check("rr drained", 32'(count), 32'h0);
        check("rr idle", 32'(bus.gnt_valid), 32'h0);

        // Reserved credit: dec on the offered channel is ignored while the offer stalls
        do_reset("rsv");
        step(4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0, "rsv fill");
        step(4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b0, "rsv offer");
        check("rsv id3", 32'(bus.gnt_id), 32'd3);
        for (int n = 0; n < 5; n++) step(4'b0000, 4'b0000, 4'b1000, 4'b0000, 1'b0, "rsv hold");
        check("rsv hold id", 32'(bus.gnt_id), 32'd3);
        check("rsv hold cnt", cnt_of(3), 32'd1);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, "rsv accept");
        check("rsv accept cnt", cnt_of(3), 32'd0);
        step(4'b0000, 4'b0101, 4'b0000, 4'b0000, 1'b0, "rsv refill");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0101, 1'b0, "rsv next");
        check("rsv next id0", 32'(bus.gnt_id), 32'd0);

        // Reset mid-offer, then withdraw by clear with simultaneous ready
        do_reset("midoffer");
        step(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, "wd fill");
        step(4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b0, "wd offer");
        check("wd offered", 32'(bus.gnt_valid), 32'h1);
        step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b1, "wd clear");
        check("wd cnt1=0", cnt_of(1), 32'd0);
        check("wd withdrawn", 32'(bus.gnt_valid), 32'h0);
        for (int n = 0; n < 5; n++) step(4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, "wd fill5");
        step(4'b0000, 4'b0010, 4'b0010, 4'b0000, 1'b0, "incdec");
        check("incdec hold5", cnt_of(1), 32'd5);

        // Randomized traffic against the model
        do_reset("rand");
        for (int n = 0; n < 600; n++) begin
            rc   = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
            ri   = 4'($urandom);
            rd   = 4'($urandom) & 4'($urandom);
            rr   = 4'($urandom);
            rrdy = ($urandom_range(0, 2) != 0);
            step(rc, ri, rd, rr, rrdy, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
